// File: rtl/div_pkg.sv
// Shared types for the divider issue controller: FSM encoding and the
// layout of the divider IP result word.
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_t;

    // dout_tdata is {quotient, remainder}; these pick the W-bit half.
    localparam int REM_HALF = 0;
    localparam int QUO_HALF = 1;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// AXI-stream side of the divider issue controller: issue channels and
// result channels of the signed and unsigned divider IPs.
interface div_issue_ctrl_if #(
    parameter int W = 32
);
    logic           s_div_tvalid;
    logic           s_div_tready;
    logic           u_div_tvalid;
    logic           u_div_tready;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           s_dout_tvalid;
    logic [2*W-1:0] s_dout_tdata;
    logic           u_dout_tvalid;
    logic [2*W-1:0] u_dout_tdata;

    modport master (
        output s_div_tvalid, u_div_tvalid, div_dividend, div_divisor,
        input  s_div_tready, u_div_tready,
        input  s_dout_tvalid, s_dout_tdata, u_dout_tvalid, u_dout_tdata
    );

    modport slave (
        input  s_div_tvalid, u_div_tvalid, div_dividend, div_divisor,
        output s_div_tready, u_div_tready,
        output s_dout_tvalid, s_dout_tdata, u_dout_tvalid, u_dout_tdata
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Issues one EX-stage division to the signed or unsigned divider IP,
// holds the selected result until retirement and drains results after a flush.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no op; capture operands on req_valid & !flush
// ISSUE    | tvalid to the selected IP until it accepts
// WAIT     | op accepted, waiting for the selected dout_tvalid
// DONE     | result held on res_data until ex_accept or flush
// DRAIN    | flushed op in flight; discard its result, then IDLE
module div_issue_ctrl
    import div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic          req_valid,
    input  logic          req_signed,
    input  logic          req_mod,
    input  logic [W-1:0]  req_dividend,
    input  logic [W-1:0]  req_divisor,
    input  logic          ex_accept,
    output logic          res_valid,
    output logic [W-1:0]  res_data,
    output logic          busy,
    div_issue_ctrl_if.master dbus
);

    div_state_t     state;
    div_state_t     state_nxt;
    logic           load_op;
    logic           load_res;
    logic           sel_signed;
    logic           sel_mod;
    logic [W-1:0]   dividend_q;
    logic [W-1:0]   divisor_q;
    logic [W-1:0]   res_q;
    logic           sel_tready;
    logic           sel_dout_valid;
    logic [2*W-1:0] sel_dout_data;
    logic [W-1:0]   sel_quo;
    logic [W-1:0]   sel_rem;

    // Only the IP chosen at capture time is ever listened to.
    assign sel_tready     = sel_signed ? dbus.s_div_tready  : dbus.u_div_tready;
    assign sel_dout_valid = sel_signed ? dbus.s_dout_tvalid : dbus.u_dout_tvalid;
    assign sel_dout_data  = sel_signed ? dbus.s_dout_tdata  : dbus.u_dout_tdata;
    assign sel_quo        = sel_dout_data[QUO_HALF*W +: W];
    assign sel_rem        = sel_dout_data[REM_HALF*W +: W];

    always_comb begin
        state_nxt = state;
        load_op   = 1'b0;
        load_res  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    state_nxt = ST_ISSUE;
                    load_op   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (sel_tready) begin
                    state_nxt = flush ? ST_DRAIN : ST_WAIT;
                end else if (flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (sel_dout_valid) begin
                    if (flush) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DONE;
                        load_res  = 1'b1;
                    end
                end else if (flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (ex_accept || flush) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (sel_dout_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            sel_signed <= 1'b0;
            sel_mod    <= 1'b0;
            dividend_q <= '0;
            divisor_q  <= '0;
            res_q      <= '0;
        end else begin
            state <= state_nxt;
            if (load_op) begin
                sel_signed <= req_signed;
                sel_mod    <= req_mod;
                dividend_q <= req_dividend;
                divisor_q  <= req_divisor;
            end
            if (load_res) begin
                res_q <= sel_mod ? sel_rem : sel_quo;
            end
        end
    end

    assign res_valid         = (state == ST_DONE);
    assign res_data          = res_q;
    assign busy              = (state != ST_IDLE);
    assign dbus.s_div_tvalid = (state == ST_ISSUE) &&  sel_signed;
    assign dbus.u_div_tvalid = (state == ST_ISSUE) && !sel_signed;
    assign dbus.div_dividend = dividend_q;
    assign dbus.div_divisor  = divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with 8-cycle behavioural models of
// the signed and unsigned divider IPs.
module tb_div_issue_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         req_valid;
    logic         req_signed;
    logic         req_mod;
    logic [W-1:0] req_dividend;
    logic [W-1:0] req_divisor;
    logic         ex_accept;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         busy;

    div_issue_ctrl_if #(.W(W)) dif();

    div_issue_ctrl #(.W(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_signed   (req_signed),
        .req_mod      (req_mod),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .ex_accept    (ex_accept),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .busy         (busy),
        .dbus         (dif)
    );

    always #5 clk = ~clk;

    // Divider IP models: result pulse 8 cycles after the accepting edge.
    logic [3:0]   s_cnt = '0;
    logic [3:0]   u_cnt = '0;
    logic [W-1:0] s_q = '0, s_r = '0, u_q = '0, u_r = '0;
    int           s_hs = 0, u_hs = 0, s_tv = 0;

    always @(posedge clk) begin
        if (dif.s_div_tvalid && dif.s_div_tready) begin
            s_cnt <= 4'd8;
            s_q   <= $signed(dif.div_dividend) / $signed(dif.div_divisor);
            s_r   <= $signed(dif.div_dividend) % $signed(dif.div_divisor);
            s_hs  <= s_hs + 1;
        end else if (s_cnt != 4'd0) begin
            s_cnt <= s_cnt - 4'd1;
        end
        if (dif.u_div_tvalid && dif.u_div_tready) begin
            u_cnt <= 4'd8;
            u_q   <= dif.div_dividend / dif.div_divisor;
            u_r   <= dif.div_dividend % dif.div_divisor;
            u_hs  <= u_hs + 1;
        end else if (u_cnt != 4'd0) begin
            u_cnt <= u_cnt - 4'd1;
        end
        if (dif.s_div_tvalid) s_tv <= s_tv + 1;
    end

    assign dif.s_dout_tvalid = (s_cnt == 4'd1);
    assign dif.s_dout_tdata  = {s_q, s_r};
    assign dif.u_dout_tvalid = (u_cnt == 4'd1);
    assign dif.u_dout_tdata  = {u_q, u_r};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_req(input logic sg, input logic md,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid    = 1'b1;
        req_signed   = sg;
        req_mod      = md;
        req_dividend = a;
        req_divisor  = b;
    endtask

    task automatic wait_res(input string tag, input int exp_lat);
        int n = 0;
        while (!res_valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic accept(input string tag);
        ex_accept = 1'b1;
        tick();
        ex_accept = 1'b0;
        req_valid = 1'b0;
        chk({tag, "_acc_rv"}, res_valid, 0);
        chk({tag, "_acc_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int h0;
        resetn = 1'b0; flush = 1'b0; ex_accept = 1'b0;
        req_valid = 1'b0; req_signed = 1'b0; req_mod = 1'b0;
        req_dividend = '0; req_divisor = '0;
        dif.s_div_tready = 1'b1;
        dif.u_div_tready = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_rd", res_data, 0);
        chk("rst_stv", dif.s_div_tvalid, 0);
        chk("rst_utv", dif.u_div_tvalid, 0);
        chk("rst_dvd", dif.div_dividend, 0);
        chk("rst_dvs", dif.div_divisor, 0);
        resetn = 1'b1;

        // signed -7 / 2
        start_req(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);
        tick();
        chk("sdiv_stv", dif.s_div_tvalid, 1);
        chk("sdiv_utv", dif.u_div_tvalid, 0);
        chk("sdiv_dvd", dif.div_dividend, 32'hFFFF_FFF9);
        chk("sdiv_dvs", dif.div_divisor, 32'd2);
        tick();
        chk("sdiv_stv_drop", dif.s_div_tvalid, 0);
        chk("sdiv_busy", busy, 1);
        wait_res("sdiv", 8);
        chk("sdiv_res", res_data, 32'hFFFF_FFFD);
        accept("sdiv");

        // signed -7 % 2
        start_req(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        tick();
        tick();
        wait_res("smod", 8);
        chk("smod_res", res_data, 32'hFFFF_FFFF);
        accept("smod");

        // unsigned 0xFFFFFFFF % 16 with tready low for 3 cycles, then DONE hold
        dif.u_div_tready = 1'b0;
        h0 = s_tv;
        start_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd16);
        tick();
        req_dividend = 32'h0000_1234;
        req_divisor  = 32'd3;
        for (int i = 0; i < 3; i++) begin
            chk("umod_utv_hold", dif.u_div_tvalid, 1);
            chk("umod_dvd_stable", dif.div_dividend, 32'hFFFF_FFFF);
            chk("umod_dvs_stable", dif.div_divisor, 32'd16);
            tick();
        end
        dif.u_div_tready = 1'b1;
        chk("umod_utv_4th", dif.u_div_tvalid, 1);
        tick();
        chk("umod_utv_drop", dif.u_div_tvalid, 0);
        wait_res("umod", 8);
        chk("umod_res", res_data, 32'h0000_000F);
        chk("umod_no_stv", s_tv - h0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("done_hold_rv", res_valid, 1);
            chk("done_hold_rd", res_data, 32'h0000_000F);
        end
        accept("done");

        // flush 3 cycles into WAIT -> DRAIN; new request waits
        start_req(1'b1, 1'b0, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start_req(1'b0, 1'b0, 32'd1000, 32'd10);
        chk("drain_busy", busy, 1);
        chk("drain_rv", res_valid, 0);
        n = 0;
        while (busy && n < 20) begin
            chk("drain_utv", dif.u_div_tvalid, 0);
            chk("drain_rv_low", res_valid, 0);
            tick();
            n++;
        end
        chk("drain_len", n, 5);
        tick();
        chk("post_drain_utv", dif.u_div_tvalid, 1);
        chk("post_drain_dvd", dif.div_dividend, 32'd1000);
        tick();
        wait_res("post_drain", 8);
        chk("post_drain_res", res_data, 32'd100);
        accept("post_drain");

        // flush in ISSUE with no handshake
        dif.s_div_tready = 1'b0;
        h0 = s_hs;
        start_req(1'b1, 1'b0, 32'd50, 32'd5);
        tick();
        chk("iss_fl_stv", dif.s_div_tvalid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("iss_fl_stv_drop", dif.s_div_tvalid, 0);
        chk("iss_fl_busy", busy, 0);
        chk("iss_fl_no_hs", s_hs - h0, 0);
        dif.s_div_tready = 1'b1;

        // flush coincident with handshake -> DRAIN
        h0 = s_hs;
        start_req(1'b1, 1'b0, 32'd20, 32'd6);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("hs_fl_busy", busy, 1);
        chk("hs_fl_stv", dif.s_div_tvalid, 0);
        chk("hs_fl_hs", s_hs - h0, 1);
        n = 0;
        while (busy && n < 20) begin
            chk("hs_fl_rv_low", res_valid, 0);
            tick();
            n++;
        end
        chk("hs_fl_drain_len", n, 8);

        // flush coincident with dout_tvalid in WAIT
        start_req(1'b0, 1'b0, 32'd9, 32'd4);
        tick();
        tick();
        n = 0;
        while (!dif.u_dout_tvalid && n < 20) begin
            tick();
            n++;
        end
        chk("dv_fl_wait", n, 7);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("dv_fl_busy", busy, 0);
        chk("dv_fl_rv", res_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dv_fl_rv_later", res_valid, 0);
        end

        // reset in WAIT, then a normal op
        start_req(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
        tick();
        tick();
        tick();
        resetn = 1'b0;
        req_valid = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rv", res_valid, 0);
        chk("mid_rst_rd", res_data, 0);
        chk("mid_rst_dvd", dif.div_dividend, 0);
        chk("mid_rst_dvs", dif.div_divisor, 0);
        chk("mid_rst_stv", dif.s_div_tvalid, 0);
        repeat (11) tick();
        resetn = 1'b1;
        start_req(1'b0, 1'b1, 32'd77, 32'd10);
        tick();
        chk("after_rst_utv", dif.u_div_tvalid, 1);
        tick();
        wait_res("after_rst", 8);
        chk("after_rst_res", res_data, 32'd7);
        accept("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Sequences the two AXI-stream divider IPs (signed, unsigned) on behalf of the EX stage.
- Captures operands once per division instruction, performs the tvalid/tready issue handshake and waits for dout tvalid.
- Holds the selected quotient or remainder until EX retires the instruction.
- Divider IPs cannot be cancelled, so on a pipeline flush it drains in-flight results before a new division may issue.

Parameters:
- W, 32, operand/result width; divider dout_tdata is 2*W as {quotient, remainder}.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- flush  in  1  exception/ertn flush of EX; cancels current op
- req_valid  in  1  EX holds a valid div/mod instruction not yet completed (level, held until ex_accept or flush)
- req_signed  in  1  1 = div.w/mod.w, 0 = div.wu/mod.wu
- req_mod  in  1  1 = return remainder, 0 = quotient
- req_dividend  in  W  rj value
- req_divisor  in  W  rk value
- ex_accept  in  1  EX hands instruction to MEM this cycle (ex_readygo & mem_allowin)
- res_valid  out  1  result ready; used as EX readygo for div ops
- res_data  out  W  selected quotient/remainder
- busy  out  1  state != IDLE
- s_div_tvalid  out  1  issue valid, signed IP (dividend and divisor channels tied)
- s_div_tready  in  1  AND of the signed IP's dividend and divisor tready
- u_div_tvalid  out  1  issue valid, unsigned IP
- u_div_tready  in  1  AND of the unsigned IP's tready signals
- div_dividend  out  W  registered dividend, shared by both IPs
- div_divisor  out  W  registered divisor, shared by both IPs
- s_dout_tvalid  in  1  signed IP result valid (single-cycle pulse)
- s_dout_tdata  in  2W  signed {q, r}
- u_dout_tvalid  in  1  unsigned IP result valid
- u_dout_tdata  in  2W  unsigned {q, r}

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset: state=IDLE; res_valid=0, res_data=0, busy=0, s_div_tvalid=0, u_div_tvalid=0, div_dividend=0, div_divisor=0, sel_signed=0, sel_mod=0.
- IDLE: if req_valid & !flush, register dividend, divisor, sel_signed and sel_mod, then go to ISSUE. Otherwise stay.
- ISSUE:
  - Asserts s_div_tvalid if sel_signed, else u_div_tvalid; never both.
  - Operands are stable while tvalid is high.
  - Handshake = tvalid & selected tready.
  - Handshake & !flush -> WAIT.
  - Handshake & flush -> DRAIN (the IP has accepted the op).
  - !handshake & flush -> IDLE; tvalid drops next cycle.
  - Otherwise stay in ISSUE.
- WAIT: tvalid low.
  - Selected dout_tvalid & !flush: latch res_data = sel_mod ? tdata[W-1:0] : tdata[2W-1:W], then go to DONE.
  - dout_tvalid & flush -> IDLE; result dropped.
  - flush only -> DRAIN.
- DONE: res_valid=1 and res_data held stable.
  - ex_accept | flush -> IDLE; res_valid is 0 in the next cycle.
- DRAIN: waits for the selected dout_tvalid, which is discarded, then -> IDLE.
  - req_valid and flush are ignored; busy=1 and res_valid=0.
  - EX must not issue a new div while busy; the new req waits in IDLE.
- Selection: dout_tvalid from the non-selected IP is ignored in every state. Both dout_tvalid inputs are ignored in IDLE, ISSUE and DONE.
- Latency: req_valid seen in cycle 0 -> tvalid in cycle 1; with tready=1, handshake in cycle 1; res_valid one cycle after dout_tvalid.
- Back-to-back ops: ex_accept in DONE -> IDLE; the next instruction's req_valid is sampled in IDLE one cycle later. Minimum gap of 2 cycles between issues.
- Divide by zero: no special case; IP output is passed through.
- Reset mid-operation: returns to IDLE immediately. Top level holds resetn ≥ divider latency so no stale dout_tvalid arrives after release.

Decomposition:
- Shared package div_pkg holds:
  - state enum/localparams (IDLE=0, ISSUE=1, WAIT=2, DONE=3, DRAIN=4, 3-bit);
  - quotient/remainder field slice constants.
- Single flat module; no sub-module needed. The divider IPs are instantiated by the EX stage, not inside this block.

Test Plan:
- Signed div, dividend=-7 (0xFFFFFFF9), divisor=2, req_mod=0, IP model 8-cycle latency, tready=1 -> s_div_tvalid one cycle, res_valid with res_data=0xFFFFFFFD; same inputs with req_mod=1 -> 0xFFFFFFFF.
- Unsigned mod 0xFFFFFFFF % 16, tready low for 3 cycles -> u_div_tvalid held 4 cycles with stable operands, s_div_tvalid never asserted, res_data=0x0000000F.
- DONE with ex_accept low for 5 cycles -> res_valid and res_data held; ex_accept pulse -> res_valid=0 and busy=0 next cycle.
- Flush 3 cycles into WAIT -> DRAIN, busy=1; new req_valid ignored until model dout_tvalid, then IDLE; next op issues and returns its own correct result, not the stale one.
- Flush in ISSUE with tready=0 -> IDLE, no handshake. Flush coincident with the handshake -> DRAIN. Flush coincident with dout_tvalid in WAIT -> IDLE, res_valid never set.
- resetn low in WAIT (held ≥ latency) -> all outputs 0, state IDLE; a subsequent op completes normally.
